// File: rtl/uart_autobaud_pkg.sv
// Shared definitions for the auto-baud UART: receiver state encoding and
// the default values of the block parameters.
package uart_autobaud_pkg;

    localparam int DATA_BITS_DEF  = 8;
    localparam int CNT_W_DEF      = 16;
    localparam int MIN_PERIOD_DEF = 4;
    localparam int IDLE_CLKS_DEF  = 4000;

    typedef enum logic [2:0] {
        RX_UNLOCKED = 3'd0,
        RX_MEASURE  = 3'd1,
        RX_IDLE     = 3'd2,
        RX_START    = 3'd3,
        RX_DATA     = 3'd4,
        RX_STOP     = 3'd5
    } rx_state_e;

endpackage

// File: rtl/uart_autobaud_tx.sv
// Transmitter: start bit, DATA_BITS data bits LSB first, one stop bit,
// each held for the bit period captured when the request is accepted.
module uart_autobaud_tx
    import uart_autobaud_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_W-1:0]     period,
    input  logic                 transmit,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 busy
);

    logic                 busy_q;
    logic                 tx_q;
    logic [CNT_W-1:0]     period_q;
    logic [CNT_W-1:0]     timer_q;
    logic [3:0]           left_q;
    logic [DATA_BITS:0]   shreg_q;

    // Accept a request when idle, then shift one symbol out per bit period.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            tx_q     <= 1'b1;
            period_q <= '0;
            timer_q  <= '0;
            left_q   <= 4'd0;
            shreg_q  <= '0;
        end else if (!busy_q) begin
            if (transmit) begin
                busy_q   <= 1'b1;
                tx_q     <= 1'b0;
                period_q <= period;
                timer_q  <= period - CNT_W'(1);
                left_q   <= 4'(DATA_BITS + 1);
                shreg_q  <= {1'b1, data};
            end
        end else if (timer_q != '0) begin
            timer_q <= timer_q - CNT_W'(1);
        end else if (left_q != 4'd0) begin
            tx_q    <= shreg_q[0];
            shreg_q <= {1'b0, shreg_q[DATA_BITS:1]};
            left_q  <= left_q - 4'd1;
            timer_q <= period_q - CNT_W'(1);
        end else begin
            busy_q <= 1'b0;
            tx_q   <= 1'b1;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: rtl/uart_autobaud_gen.sv
// Auto-baud UART. The first frame after reset (or after a relock) is
// measured from its start bit, which must be the only low bit before the
// first rising edge (data LSB = 1); that frame is then received normally.
// Optional feature macro: UART_AUTOBAUD_RELOCK_EN -- drop the lock after
// IDLE_CLKS quiet cycles so the next frame is re-measured.
module uart_autobaud_gen
    import uart_autobaud_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF,
    parameter int IDLE_CLKS  = IDLE_CLKS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 transmit,
    input  logic [DATA_BITS-1:0] data_tx,
    output logic [DATA_BITS-1:0] data_rx,
    output logic                 recieved,
    output logic                 busy_rx,
    output logic                 busy_tx,
    output logic                 locked,
    output logic [CNT_W-1:0]     baud_period,
    output logic                 frame_err
);

    localparam int BIT_W = 4;

    rx_state_e            state_q;
    logic                 rx_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     timer_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] data_rx_q;
    logic [CNT_W-1:0]     baud_q;
    logic                 locked_q;
    logic                 recv_q;
    logic                 ferr_q;
    logic                 busy_rx_q;
    logic                 rx_fall_s;
    logic                 relock_s;
    logic                 tx_busy_s;

    assign rx_fall_s = rx_q & ~rx;

`ifdef UART_AUTOBAUD_RELOCK_EN
    localparam int IDLE_W = $clog2(IDLE_CLKS + 1);
    logic [IDLE_W-1:0] idle_q;

    assign relock_s = rx && !busy_rx_q && !tx_busy_s &&
                      (idle_q == IDLE_W'(IDLE_CLKS - 1));

    // Count consecutive quiet cycles; any line or frame activity restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
        end else if (!rx || busy_rx_q || tx_busy_s || relock_s) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + IDLE_W'(1);
        end
    end
`else
    assign relock_s = 1'b0;
`endif

    // Receiver FSM: measure the lock frame's start bit, then sample frames
    // at mid-bit using the measured period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RX_UNLOCKED;
            rx_q      <= 1'b1;
            cnt_q     <= '0;
            timer_q   <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            data_rx_q <= '0;
            baud_q    <= '0;
            locked_q  <= 1'b0;
            recv_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_rx_q <= 1'b0;
        end else begin
            rx_q   <= rx;
            recv_q <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                RX_UNLOCKED: begin
                    if (rx_fall_s) begin
                        state_q   <= RX_MEASURE;
                        cnt_q     <= CNT_W'(1);
                        busy_rx_q <= 1'b1;
                    end
                end
                RX_MEASURE: begin
                    if (!rx) begin
                        if (cnt_q == '1) begin
                            state_q   <= RX_UNLOCKED;
                            busy_rx_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (cnt_q >= CNT_W'(MIN_PERIOD)) begin
                        // Rising edge opens bit0; first sample lands mid-bit.
                        baud_q   <= cnt_q;
                        locked_q <= 1'b1;
                        timer_q  <= (cnt_q >> 1) - CNT_W'(1);
                        bit_q    <= '0;
                        state_q  <= RX_DATA;
                    end else begin
                        state_q   <= RX_UNLOCKED;
                        busy_rx_q <= 1'b0;
                    end
                end
                RX_IDLE: begin
                    if (relock_s) begin
                        state_q  <= RX_UNLOCKED;
                        locked_q <= 1'b0;
                    end else if (rx_fall_s) begin
                        state_q   <= RX_START;
                        timer_q   <= (baud_q >> 1) - CNT_W'(1);
                        busy_rx_q <= 1'b1;
                    end
                end
                RX_START: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - CNT_W'(1);
                    end else if (!rx) begin
                        state_q <= RX_DATA;
                        timer_q <= baud_q - CNT_W'(1);
                        bit_q   <= '0;
                    end else begin
                        state_q   <= RX_IDLE;
                        busy_rx_q <= 1'b0;
                    end
                end
                RX_DATA: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - CNT_W'(1);
                    end else begin
                        shreg_q <= {rx, shreg_q[DATA_BITS-1:1]};
                        timer_q <= baud_q - CNT_W'(1);
                        if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end
                end
                RX_STOP: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - CNT_W'(1);
                    end else begin
                        if (rx) begin
                            data_rx_q <= shreg_q;
                            recv_q    <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                        state_q   <= RX_IDLE;
                        busy_rx_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= RX_UNLOCKED;
                    locked_q  <= 1'b0;
                    busy_rx_q <= 1'b0;
                end
            endcase
        end
    end

    uart_autobaud_tx #(
        .DATA_BITS (DATA_BITS),
        .CNT_W     (CNT_W)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .period   (baud_q),
        .transmit (transmit & locked_q),
        .data     (data_tx),
        .tx       (tx),
        .busy     (tx_busy_s)
    );

    assign busy_tx     = tx_busy_s;
    assign data_rx     = data_rx_q;
    assign recieved    = recv_q;
    assign frame_err   = ferr_q;
    assign busy_rx     = busy_rx_q;
    assign locked      = locked_q;
    assign baud_period = baud_q;

endmodule
